alu_secuencial: RTL

Multi-cycle 32-bit ALU that executes the 4-bit operation codes produced by the ALU control decoder. Single-cycle operations complete in one clock. Shifts are iterative, one bit position per clock, to save area. It sits in the execute stage: operands come from the register file and immediate mux, and `resultado` and `zero` feed the writeback mux and branch logic.

---
 rtl/alu_secuencial.sv | 136 +++++++++++++
 1 files changed

// File: rtl/alu_secuencial.sv
// Multi-cycle 32-bit execute-stage ALU: logic/arithmetic/compare ops finish in one
// clock, shifts iterate one bit position per clock through an accumulator.
module alu_secuencial (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [3:0]  ALUcontrol,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] resultado,
    output logic        zero,
    output logic        busy,
    output logic        done
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_NE   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_XOR  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_GE   = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_SRA  = 4'b1110;
    localparam logic [3:0] OP_EQ   = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [31:0] acc, acc_n;
    logic [4:0]  cnt, cnt_n;
    logic [3:0]  op_q, op_n;
    logic [31:0] res_n;
    logic        zero_n;
    logic        done_n;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    // Single-cycle datapath; shift and undefined codes fall through to 0.
    function automatic logic [31:0] alu_comb(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            OP_SLTU: r = {31'b0, a < b};
            OP_EQ:   r = {31'b0, a == b};
            OP_NE:   r = {31'b0, a != b};
            OP_GE:   r = {31'b0, $signed(a) >= $signed(b)};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Handshake: a request is taken on any rising edge where start=1 and busy=0
    // (state IDLE); start while busy is dropped, not queued. Every accepted
    // request produces exactly one done pulse unless RESET intervenes.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        op_n    = op_q;
        res_n   = resultado;
        zero_n  = zero;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (is_shift(ALUcontrol)) begin
                        acc_n   = A;
                        cnt_n   = B[4:0];
                        op_n    = ALUcontrol;
                        state_n = SHIFT;
                    end else begin
                        res_n  = alu_comb(ALUcontrol, A, B);
                        zero_n = (res_n == 32'd0);
                        done_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (cnt != 5'd0) begin
                    cnt_n = cnt - 5'd1;
                    case (op_q)
                        OP_SLL:  acc_n = {acc[30:0], 1'b0};
                        OP_SRL:  acc_n = {1'b0, acc[31:1]};
                        default: acc_n = {acc[31], acc[31:1]};
                    endcase
                end else begin
                    res_n   = acc;
                    zero_n  = (acc == 32'd0);
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            acc       <= 32'd0;
            cnt       <= 5'd0;
            op_q      <= OP_ADD;
            resultado <= 32'd0;
            zero      <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            op_q      <= op_n;
            resultado <= res_n;
            zero      <= zero_n;
            done      <= done_n;
        end
    end

    assign busy = (state == SHIFT);

endmodule
